// File: rtl/pll_lock_sequencer.sv
// Bring-up sequencer for the pixel-clock PLL: reset hold, lock wait with timeout,
// lock qualification, run-time lock monitoring and fault latching after repeated failures.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_req,
  output logic       pll_rst,
  output logic       clk_ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [7:0] retry_count,
  output logic [7:0] relock_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAULT      = 3'd4
  } state_e;

  localparam logic [19:0] RST_LAST    = 20'(RST_CYCLES - 1);
  localparam logic [19:0] LOCK_LAST   = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] STABLE_LAST = 20'(STABLE_CYCLES - 1);
  localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRIES);
  localparam logic [19:0] TIMER_MAX   = 20'hF_FFFF;

  state_e      state_q, state_d;
  logic [19:0] timer_q, timer_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  relock_q, relock_d;
  logic [7:0]  retry_inc_s;
  logic        sync1_q, lock_s_q;
  logic        restart_s;
  logic        lock_lost_d;
  logic        pll_rst_q, clk_ready_q, fault_q, lock_lost_q;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      lock_s_q <= sync1_q;
    end
  end

  assign retry_inc_s = retry_q + 8'd1;

  // Next-state, counter and timer logic; soft_req overrides every other transition.
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    relock_d    = relock_q;
    restart_s   = 1'b0;
    lock_lost_d = 1'b0;
    if (soft_req) begin
      state_d   = ST_RESET_HOLD;
      retry_d   = 8'd0;
      restart_s = 1'b1;
    end else begin
      case (state_q)
        ST_RESET_HOLD: begin
          if (timer_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
          end else begin
            state_d = ST_RESET_HOLD;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = ST_STABLE;
          end else if (timer_q == LOCK_LAST) begin
            retry_d = retry_inc_s;
            if (retry_inc_s == RETRY_LIMIT) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_RESET_HOLD;
            end
          end else begin
            state_d = ST_WAIT_LOCK;
          end
        end
        ST_STABLE: begin
          // A dropout restarts the lock wait without counting as a retry.
          if (!lock_s_q) begin
            state_d = ST_WAIT_LOCK;
          end else if (timer_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = 8'd0;
          end else begin
            state_d = ST_STABLE;
          end
        end
        ST_RUN: begin
          if (!lock_s_q) begin
            state_d     = ST_RESET_HOLD;
            lock_lost_d = 1'b1;
            if (relock_q != 8'hFF) begin
              relock_d = relock_q + 8'd1;
            end else begin
              relock_d = relock_q;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RESET_HOLD;
        end
      endcase
    end
    if (restart_s || (state_d != state_q)) begin
      timer_d = 20'd0;
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + 20'd1;
    end else begin
      timer_d = timer_q;
    end
  end

  // State, timer and counter registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RESET_HOLD;
      timer_q  <= 20'd0;
      retry_q  <= 8'd0;
      relock_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      relock_q <= relock_d;
    end
  end

  // Output flops decoded from the next state so they stay aligned with state_q.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      fault_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      pll_rst_q   <= (state_d == ST_RESET_HOLD) || (state_d == ST_FAULT);
      clk_ready_q <= (state_d == ST_RUN);
      fault_q     <= (state_d == ST_FAULT);
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign clk_ready    = clk_ready_q;
  assign fault        = fault_q;
  assign lock_lost    = lock_lost_q;
  assign retry_count  = retry_q;
  assign relock_count = relock_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: directed stimulus schedules expected
// output values at absolute clock edges; a negedge monitor pops and compares them.
module tb_pll_lock_sequencer;

  localparam int SEL_STATE     = 0;
  localparam int SEL_PLL_RST   = 1;
  localparam int SEL_CLK_READY = 2;
  localparam int SEL_FAULT     = 3;
  localparam int SEL_LOCK_LOST = 4;
  localparam int SEL_RETRY     = 5;
  localparam int SEL_RELOCK    = 6;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_req;
  logic       pll_rst;
  logic       clk_ready;
  logic       fault;
  logic       lock_lost;
  logic [7:0] retry_count;
  logic [7:0] relock_count;
  logic [2:0] state;

  pll_lock_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (3)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .soft_req    (soft_req),
    .pll_rst     (pll_rst),
    .clk_ready   (clk_ready),
    .fault       (fault),
    .lock_lost   (lock_lost),
    .retry_count (retry_count),
    .relock_count(relock_count),
    .state       (state)
  );

  typedef struct {
    int    due;
    string tag;
    int    sel;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  always @(posedge refclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      SEL_STATE:     obs = {29'd0, state};
      SEL_PLL_RST:   obs = {31'd0, pll_rst};
      SEL_CLK_READY: obs = {31'd0, clk_ready};
      SEL_FAULT:     obs = {31'd0, fault};
      SEL_LOCK_LOST: obs = {31'd0, lock_lost};
      SEL_RETRY:     obs = {24'd0, retry_count};
      SEL_RELOCK:    obs = {24'd0, relock_count};
      default:       obs = 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every expectation that has come due at this edge.
  always @(negedge refclk) begin
    exp_t keep_q[$];
    keep_q = {};
    foreach (sb_q[i]) begin
      if (sb_q[i].due <= cyc) check_eq(sb_q[i].tag, obs(sb_q[i].sel), sb_q[i].val);
      else keep_q.push_back(sb_q[i]);
    end
    sb_q = keep_q;
  end

  task automatic expect_at(input int due, input string tag, input int sel, input int val);
    exp_t e;
    e.due = due;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic wait_to(input int e);
    while (cyc < e) tick(1);
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_state"}, obs(SEL_STATE), 0);
    check_eq({pfx, "_pll_rst"}, obs(SEL_PLL_RST), 1);
    check_eq({pfx, "_clk_ready"}, obs(SEL_CLK_READY), 0);
    check_eq({pfx, "_fault"}, obs(SEL_FAULT), 0);
    check_eq({pfx, "_lock_lost"}, obs(SEL_LOCK_LOST), 0);
    check_eq({pfx, "_retry"}, obs(SEL_RETRY), 0);
    check_eq({pfx, "_relock"}, obs(SEL_RELOCK), 0);
  endtask

  task automatic do_soft(output int n);
    soft_req = 1'b1;
    tick(1);
    soft_req = 1'b0;
    n = cyc;
    expect_at(n, "soft_state", SEL_STATE, 0);
    expect_at(n, "soft_pll_rst", SEL_PLL_RST, 1);
    expect_at(n, "soft_clk_ready", SEL_CLK_READY, 0);
    expect_at(n, "soft_fault", SEL_FAULT, 0);
    expect_at(n, "soft_retry", SEL_RETRY, 0);
  endtask

  // pll_rst fell after edge w; raise lock so it is first sampled at edge w+10.
  task automatic lock_after(input int w);
    int k;
    wait_to(w + 9);
    pll_locked = 1'b1;
    k = w + 10;
    expect_at(k + 1, "lk_still_wait", SEL_STATE, 1);
    expect_at(k + 2, "lk_stable", SEL_STATE, 2);
    expect_at(k + 9, "lk_ready_early", SEL_CLK_READY, 0);
    expect_at(k + 10, "lk_ready", SEL_CLK_READY, 1);
    expect_at(k + 10, "lk_run", SEL_STATE, 3);
    expect_at(k + 10, "lk_retry", SEL_RETRY, 0);
    expect_at(k + 10, "lk_pll_rst", SEL_PLL_RST, 0);
    wait_to(k + 11);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, edge %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, m, n, w, k1, k2, wr, f;
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    soft_req   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("por");
    expect_at(1, "rst_hold_state", SEL_STATE, 0);
    expect_at(2, "rst_hold_pll_rst", SEL_PLL_RST, 1);
    tick(3);

    // Clean bring-up.
    e0 = cyc;
    rst_n = 1'b1;
    for (int d = 0; d < 4; d++) expect_at(e0 + d, "boot_pll_rst_hi", SEL_PLL_RST, 1);
    expect_at(e0 + 4, "boot_pll_rst_lo", SEL_PLL_RST, 0);
    expect_at(e0 + 4, "boot_state_wait", SEL_STATE, 1);
    lock_after(e0 + 4);

    // Loss of lock in RUN, then relock.
    pll_locked = 1'b0;
    m = cyc + 1;
    expect_at(m + 1, "loss_ready_hold", SEL_CLK_READY, 1);
    expect_at(m + 2, "loss_ready_lo", SEL_CLK_READY, 0);
    expect_at(m + 2, "loss_pll_rst", SEL_PLL_RST, 1);
    expect_at(m + 2, "loss_pulse", SEL_LOCK_LOST, 1);
    expect_at(m + 2, "loss_relock", SEL_RELOCK, 1);
    expect_at(m + 2, "loss_state", SEL_STATE, 0);
    expect_at(m + 3, "loss_pulse_end", SEL_LOCK_LOST, 0);
    expect_at(m + 5, "loss_rst_hold", SEL_PLL_RST, 1);
    expect_at(m + 6, "loss_rst_release", SEL_PLL_RST, 0);
    wait_to(m + 2);
    lock_after(m + 6);

    // Lock glitch while qualifying.
    pll_locked = 1'b0;
    do_soft(n);
    w = n + 4;
    expect_at(w, "gl_wait", SEL_STATE, 1);
    wait_to(w + 1);
    pll_locked = 1'b1;
    k1 = w + 2;
    k2 = k1 + 6;
    expect_at(k1 + 2, "gl_stable1", SEL_STATE, 2);
    expect_at(k1 + 6, "gl_stable_hold", SEL_STATE, 2);
    expect_at(k1 + 7, "gl_back_wait", SEL_STATE, 1);
    expect_at(k1 + 7, "gl_no_pll_rst", SEL_PLL_RST, 0);
    expect_at(k1 + 7, "gl_no_retry", SEL_RETRY, 0);
    expect_at(k1 + 8, "gl_stable2", SEL_STATE, 2);
    expect_at(k2 + 9, "gl_ready_early", SEL_CLK_READY, 0);
    expect_at(k2 + 10, "gl_ready", SEL_CLK_READY, 1);
    wait_to(k1 + 4);
    pll_locked = 1'b0;
    wait_to(k1 + 5);
    pll_locked = 1'b1;
    wait_to(k2 + 11);

    // Repeated timeouts into FAULT.
    pll_locked = 1'b0;
    do_soft(n);
    for (int r = 1; r <= 3; r++) begin
      wr = n + 4 + (r - 1) * 36;
      expect_at(wr, "to_wait_state", SEL_STATE, 1);
      expect_at(wr, "to_wait_pll_rst", SEL_PLL_RST, 0);
      expect_at(wr + 31, "to_before_state", SEL_STATE, 1);
      expect_at(wr + 31, "to_before_retry", SEL_RETRY, r - 1);
      expect_at(wr + 32, "to_retry", SEL_RETRY, r);
      expect_at(wr + 32, "to_pll_rst", SEL_PLL_RST, 1);
      if (r < 3) begin
        expect_at(wr + 32, "to_rehold", SEL_STATE, 0);
        expect_at(wr + 35, "to_rehold_end", SEL_PLL_RST, 1);
      end else begin
        expect_at(wr + 32, "to_fault_state", SEL_STATE, 4);
        expect_at(wr + 32, "to_fault", SEL_FAULT, 1);
      end
    end
    f = n + 4 + 2 * 36 + 32;
    for (int d = 100; d <= 500; d += 200) begin
      expect_at(f + d, "flt_state", SEL_STATE, 4);
      expect_at(f + d, "flt_fault", SEL_FAULT, 1);
      expect_at(f + d, "flt_pll_rst", SEL_PLL_RST, 1);
      expect_at(f + d, "flt_retry", SEL_RETRY, 3);
    end
    wait_to(f + 500);

    // Recovery from FAULT.
    do_soft(n);
    expect_at(n, "rec_relock", SEL_RELOCK, 1);
    lock_after(n + 4);

    // Relock counter saturation.
    for (int i = 1; i <= 300; i++) begin
      pll_locked = 1'b0;
      tick(1);
      m = cyc;
      pll_locked = 1'b1;
      expect_at(m + 2, "sat_relock", SEL_RELOCK, (1 + i > 255) ? 255 : 1 + i);
      expect_at(m + 2, "sat_pulse", SEL_LOCK_LOST, 1);
      expect_at(m + 15, "sat_run", SEL_STATE, 3);
      wait_to(m + 16);
    end

    // Asynchronous reset while in STABLE.
    pll_locked = 1'b0;
    tick(1);
    m = cyc;
    pll_locked = 1'b1;
    wait_to(m + 9);
    check_eq("pre_rst_state", obs(SEL_STATE), 2);
    check_eq("pre_rst_relock", obs(SEL_RELOCK), 255);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid");
    tick(2);
    e0 = cyc;
    rst_n = 1'b1;
    expect_at(e0 + 4, "post_wait", SEL_STATE, 1);
    expect_at(e0 + 5, "post_stable", SEL_STATE, 2);
    expect_at(e0 + 12, "post_not_run", SEL_STATE, 2);
    expect_at(e0 + 13, "post_run", SEL_STATE, 3);
    expect_at(e0 + 13, "post_relock", SEL_RELOCK, 0);
    wait_to(e0 + 14);

    check_eq("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
